// File: rtl/playfield_ram_arbiter_if.sv
// Purpose : bundles the display, game and RAM-side signals of the playfield RAM arbiter.
// Latency : none, wiring only.
// Backpressure: game side uses valid/ready; display and RAM sides are strobes.
// Ports (signals):
//   disp_req/disp_addr -> disp_rdata/disp_rvalid   display scanout reads
//   game_valid/game_we/game_addr/game_wdata
//     -> game_ready/game_rdata/game_rvalid       game logic reads/writes
//   ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata single-port cell RAM
//   starve_err                                    sticky starvation flag
// Modports: slave = the arbiter, master = the surrounding system.
interface playfield_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 3
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    logic              game_valid;
    logic              game_ready;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic [DATA_W-1:0] game_rdata;
    logic              game_rvalid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              starve_err;

    modport slave (
        input  disp_req, disp_addr,
        input  game_valid, game_we, game_addr, game_wdata,
        input  ram_rdata,
        output disp_rdata, disp_rvalid,
        output game_ready, game_rdata, game_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output starve_err
    );

    modport master (
        output disp_req, disp_addr,
        output game_valid, game_we, game_addr, game_wdata,
        output ram_rdata,
        input  disp_rdata, disp_rvalid,
        input  game_ready, game_rdata, game_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  starve_err
    );
endinterface

// File: rtl/playfield_ram_arbiter.sv
// Purpose : shares one single-port playfield cell RAM between display scanout
//           (absolute priority) and game logic (every cycle the display leaves idle).
// Latency : grant in cycle N, RAM access N+1, rdata/rvalid out in N+3; one access per cycle.
// Backpressure: game_ready = !disp_req && !reset; display is never stalled.
// Ports:
//   pixclk_i  pixel-domain clock, rising edge
//   reset_i   asynchronous active-high reset
//   bus       playfield_ram_arbiter_if.slave (display, game and RAM signals)
module playfield_ram_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 3,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  pixclk_i,
    input  logic                  reset_i,
    playfield_ram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic OWN_GAME = 1'b0;
    localparam logic OWN_DISP = 1'b1;

    logic              game_ready;

    logic              ram_en_d, ram_en_q;
    logic              ram_we_d, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;

    // Tag {valid, owner}: tag1 travels with the RAM request, tag2 with the
    // returning RAM data. Writes carry valid=0 so they never raise rvalid.
    logic [1:0]        tag1_d, tag1_q, tag2_q;

    logic [DATA_W-1:0] disp_rdata_q, game_rdata_q;
    logic              disp_rvalid_q, game_rvalid_q;

    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic              starve_err_d, starve_err_q;

    assign game_ready = !bus.disp_req && !reset_i;

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tag1_d      = 2'b00;
        if (bus.disp_req) begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.disp_addr;
            tag1_d     = {1'b1, OWN_DISP};
        end else if (bus.game_valid) begin
            ram_en_d    = 1'b1;
            ram_we_d    = bus.game_we;
            ram_addr_d  = bus.game_addr;
            ram_wdata_d = bus.game_wdata;
            tag1_d      = {!bus.game_we, OWN_GAME};
        end
    end

    // Stall counter only runs while the game is held off; saturates, never wraps.
    always_comb begin
        stall_cnt_d = '0;
        if (bus.game_valid && !game_ready) begin
            stall_cnt_d = (stall_cnt_q == LIMIT_C) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        starve_err_d = starve_err_q || (stall_cnt_d == LIMIT_C);
    end

    always_ff @(posedge pixclk_i or posedge reset_i) begin
        if (reset_i) begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            tag1_q        <= 2'b00;
            tag2_q        <= 2'b00;
            disp_rdata_q  <= '0;
            game_rdata_q  <= '0;
            disp_rvalid_q <= 1'b0;
            game_rvalid_q <= 1'b0;
            stall_cnt_q   <= '0;
            starve_err_q  <= 1'b0;
        end else begin
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag1_q;
            disp_rvalid_q <= tag2_q[1] && (tag2_q[0] == OWN_DISP);
            game_rvalid_q <= tag2_q[1] && (tag2_q[0] == OWN_GAME);
            // Only the owner's data register updates; the other holds.
            if (tag2_q[1] && (tag2_q[0] == OWN_DISP)) disp_rdata_q <= bus.ram_rdata;
            if (tag2_q[1] && (tag2_q[0] == OWN_GAME)) game_rdata_q <= bus.ram_rdata;
            stall_cnt_q   <= stall_cnt_d;
            starve_err_q  <= starve_err_d;
        end
    end

    assign bus.game_ready  = game_ready;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.game_rdata  = game_rdata_q;
    assign bus.game_rvalid = game_rvalid_q;
    assign bus.starve_err  = starve_err_q;
endmodule

// File: tb/tb_playfield_ram_arbiter.sv
// Purpose : directed self-checking bench for playfield_ram_arbiter with a behavioural RAM.
// Latency : inputs driven 1 ns after pixclk rise, outputs sampled on the falling edge.
// Backpressure: game requests are held until game_ready is seen high.
module tb_playfield_ram_arbiter;
    logic pixclk;
    logic reset;
    int   n_cmp;
    int   n_err;

    playfield_ram_arbiter_if #(.ADDR_W(8), .DATA_W(3)) bus ();

    playfield_ram_arbiter #(.ADDR_W(8), .DATA_W(3), .STARVE_LIMIT(64)) dut (
        .pixclk_i (pixclk),
        .reset_i  (reset),
        .bus      (bus)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    // Single-port RAM model with one-cycle read latency and a preload port.
    logic [2:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [2:0] pre_dat;

    always @(posedge pixclk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge pixclk);
        #1;
    endtask

    // pat 0: cell j holds j mod 8; pat 1: cell j holds (3j+1) mod 8
    task automatic preload(input int pat);
        for (int j = 0; j < 256; j++) begin
            pre_we   = 1'b1;
            pre_addr = 8'(j);
            pre_dat  = (pat == 0) ? 3'(j % 8) : 3'((j * 3 + 1) % 8);
            next_cyc();
        end
        pre_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"},   bus.ram_en, 0);
        chk({tag, "_ram_we"},   bus.ram_we, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_wd"},   bus.ram_wdata, 0);
        chk({tag, "_ready"},    bus.game_ready, 0);
        chk({tag, "_d_rv"},     bus.disp_rvalid, 0);
        chk({tag, "_d_rd"},     bus.disp_rdata, 0);
        chk({tag, "_g_rv"},     bus.game_rvalid, 0);
        chk({tag, "_g_rd"},     bus.game_rdata, 0);
        chk({tag, "_starve"},   bus.starve_err, 0);
    endtask

    initial begin
        int cnt;
        int i;
        int exp_d;
        int last_disp;
        n_cmp = 0;
        n_err = 0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        reset = 1'b1;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.game_valid = 1'b1; bus.game_we = 1'b0;
        bus.game_addr = '0; bus.game_wdata = '0;
        bus.ram_rdata = '0;

        // ---- reset state, then 10 idle cycles
        next_cyc();
        next_cyc();
        @(negedge pixclk);
        chk_all_zero("rst");
        next_cyc();
        bus.game_valid = 1'b0;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge pixclk);
            if (bus.ram_en) cnt++;
            next_cyc();
        end
        chk("idle_ram_en_cnt", cnt, 0);
        @(negedge pixclk);
        chk("idle_rvalid", {bus.disp_rvalid, bus.game_rvalid, bus.starve_err}, 0);
        next_cyc();

        // ---- game write 0x05<=3, then game read 0x05
        bus.game_valid = 1'b1; bus.game_we = 1'b1;
        bus.game_addr = 8'h05; bus.game_wdata = 3'd3;
        @(negedge pixclk);
        chk("wr_ready", bus.game_ready, 1);
        next_cyc();
        bus.game_we = 1'b0;
        @(negedge pixclk);
        chk("wr_ram_en", bus.ram_en, 1);
        chk("wr_ram_we", bus.ram_we, 1);
        chk("wr_ram_addr", bus.ram_addr, 8'h05);
        chk("wr_ram_wd", bus.ram_wdata, 3);
        chk("rd_ready", bus.game_ready, 1);
        next_cyc();
        bus.game_valid = 1'b0;
        @(negedge pixclk);
        chk("rd_ram_en", bus.ram_en, 1);
        chk("rd_ram_we", bus.ram_we, 0);
        chk("wr_no_rv_a", bus.game_rvalid, 0);
        next_cyc();
        @(negedge pixclk);
        chk("wr_no_rv_b", bus.game_rvalid, 0);
        next_cyc();
        @(negedge pixclk);
        chk("rd_rvalid", bus.game_rvalid, 1);
        chk("rd_rdata", bus.game_rdata, 3);
        next_cyc();
        @(negedge pixclk);
        chk("rd_rv_pulse", bus.game_rvalid, 0);
        next_cyc();

        // ---- 20 display reads with game read of 0xFF held pending
        preload(0);
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            bus.disp_req   = (k < 20);
            bus.disp_addr  = 8'(k);
            bus.game_valid = (k <= 20);
            bus.game_we    = 1'b0;
            bus.game_addr  = 8'hFF;
            @(negedge pixclk);
            if (k < 20 && bus.game_ready) cnt++;
            if (k == 20) chk("ds_game_acc", bus.game_ready, 1);
            if (k == 21) begin
                chk("ds_ram_en", bus.ram_en, 1);
                chk("ds_ram_addr_ff", bus.ram_addr, 8'hFF);
            end
            if (k >= 3 && k <= 22) begin
                chk("ds_d_rv", bus.disp_rvalid, 1);
                chk("ds_d_rd", bus.disp_rdata, (k - 3) % 8);
            end else begin
                chk("ds_d_rv0", bus.disp_rvalid, 0);
            end
            chk("ds_g_rv", bus.game_rvalid, (k == 23));
            if (k == 23) chk("ds_g_rd", bus.game_rdata, 7);
            next_cyc();
        end
        chk("ds_stall_ready_cnt", cnt, 0);

        // ---- starvation: 70 display cycles with a game write pending
        for (int k = 0; k < 76; k++) begin
            bus.disp_req   = (k < 70);
            bus.disp_addr  = 8'(k);
            bus.game_valid = (k <= 70);
            bus.game_we    = 1'b1;
            bus.game_addr  = 8'hC8;
            bus.game_wdata = 3'd7;
            @(negedge pixclk);
            if (k == 0)  chk("st_err_k0", bus.starve_err, 0);
            if (k == 63) chk("st_err_k63", bus.starve_err, 0);
            if (k == 64) chk("st_err_k64", bus.starve_err, 1);
            if (k == 69) chk("st_ready_k69", bus.game_ready, 0);
            if (k == 70) chk("st_ready_k70", bus.game_ready, 1);
            if (k == 75) chk("st_err_sticky", bus.starve_err, 1);
            next_cyc();
        end

        // ---- reset one cycle after a game read is accepted
        bus.game_valid = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'hC8;
        @(negedge pixclk);
        chk("mr_ready", bus.game_ready, 1);
        next_cyc();
        reset = 1'b1;
        @(negedge pixclk);
        chk_all_zero("mr");
        next_cyc();
        bus.game_valid = 1'b0;
        next_cyc();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pixclk);
            if (bus.game_rvalid || bus.disp_rvalid) cnt++;
            next_cyc();
        end
        chk("mr_no_rvalid", cnt, 0);
        chk("mr_starve_clr", bus.starve_err, 0);
        bus.game_valid = 1'b1;
        @(negedge pixclk);
        chk("mr_resume_ready", bus.game_ready, 1);
        next_cyc();
        bus.game_valid = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge pixclk);
        chk("mr_resume_rv", bus.game_rvalid, 1);
        chk("mr_resume_rd", bus.game_rdata, 7);
        next_cyc();

        // ---- alternating display / game reads for 40 cycles
        preload(1);
        last_disp = 0;
        for (int k = 0; k < 44; k++) begin
            if (k < 40) begin
                bus.disp_req   = (k % 2 == 0);
                bus.disp_addr  = 8'(k);
                bus.game_valid = (k % 2 == 1);
                bus.game_we    = 1'b0;
                bus.game_addr  = 8'(100 + k);
            end else begin
                bus.disp_req   = 1'b0;
                bus.game_valid = 1'b0;
            end
            @(negedge pixclk);
            if (k >= 3 && k <= 42) begin
                i = k - 3;
                if (i % 2 == 0) begin
                    exp_d = (i * 3 + 1) % 8;
                    chk("alt_d_rv", bus.disp_rvalid, 1);
                    chk("alt_g_rv", bus.game_rvalid, 0);
                    chk("alt_d_rd", bus.disp_rdata, exp_d);
                    last_disp = exp_d;
                end else begin
                    exp_d = ((100 + i) * 3 + 1) % 8;
                    chk("alt_d_rv", bus.disp_rvalid, 0);
                    chk("alt_g_rv", bus.game_rvalid, 1);
                    chk("alt_g_rd", bus.game_rdata, exp_d);
                    chk("alt_d_hold", bus.disp_rdata, last_disp);
                end
            end else begin
                chk("alt_rv_idle", {bus.disp_rvalid, bus.game_rvalid}, 0);
            end
            next_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
